// File: rtl/perf_cnt_pkg.sv
// Shared definitions for the performance counter bank: config word layout,
// counting modes and read-address offsets.
package perf_cnt_pkg;

  localparam int CFG_W      = 10;
  localparam int CFG_ADDR_W = 4;
  localparam int ADDR_W     = 5;
  localparam int SEL_LSB    = 0;
  localparam int SEL_W      = 5;
  localparam int MODE_BIT   = 8;
  localparam int EN_BIT     = 9;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  typedef struct packed {
    logic             en;
    cnt_mode_e        mode;
    logic [SEL_W-1:0] sel;
  } cnt_cfg_t;

  localparam cnt_cfg_t CFG_RESET = '{en: 1'b0, mode: MODE_WRAP, sel: '0};

  function automatic cnt_cfg_t decode_cfg(input logic [CFG_W-1:0] w);
    cnt_cfg_t c;
    c.en   = w[EN_BIT];
    c.mode = cnt_mode_e'(w[MODE_BIT]);
    c.sel  = w[SEL_LSB +: SEL_W];
    return c;
  endfunction

  // Read map: counters first, then the counter-0 high word, then the ovf vector.
  function automatic int hi_ofs(input int num_cnt);
    return num_cnt;
  endfunction

  function automatic int ovf_ofs(input int num_cnt);
    return num_cnt + 1;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Config-write and read request/response channels of the counter bank.
interface perf_counter_bank_if #(
  parameter int CNT_W = 32
) ();
  import perf_cnt_pkg::*;

  logic                  cfg_wen;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  logic [CFG_W-1:0]      cfg_wdata;

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_W-1:0]     rd_addr;
  logic [CNT_W-1:0]      rd_data;
  logic                  rd_data_valid;
  logic                  rd_data_ready;

  modport master (
    output cfg_wen, cfg_addr, cfg_wdata, rd_req_valid, rd_addr, rd_data_ready,
    input  rd_req_ready, rd_data, rd_data_valid
  );

  modport slave (
    input  cfg_wen, cfg_addr, cfg_wdata, rd_req_valid, rd_addr, rd_data_ready,
    output rd_req_ready, rd_data, rd_data_valid
  );
endinterface

// File: rtl/perf_cnt_slice.sv
// One event counter (index >= 1): config register, event select, wrap or
// saturate at all-ones, sticky overflow flag.
module perf_cnt_slice
  import perf_cnt_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int EVT_W = 16,
  parameter int IDX   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [EVT_W-1:0]      evt_i,
  input  logic                  freeze_i,
  input  logic                  clear_i,
  input  logic                  cfg_wen_i,
  input  logic [CFG_ADDR_W-1:0] cfg_addr_i,
  input  cnt_cfg_t              cfg_wr_i,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  ovf_o
);

  cnt_cfg_t         cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      evt_ext;
  logic             hit;

  // Zero-extension makes any select at or beyond EVT_W read a constant 0.
  assign evt_ext = 32'(evt_i);
  assign hit     = cfg_q.en & ~freeze_i & evt_ext[cfg_q.sel];

  always_comb begin
    cfg_d = cfg_q;
    if (cfg_wen_i && (cfg_addr_i == CFG_ADDR_W'(IDX))) cfg_d = cfg_wr_i;
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (hit) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (cfg_q.mode == MODE_SAT) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= CFG_RESET;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of performance counters: counter 0 is a free-running cycle counter with
// a rollover high word, counters 1..NUM_CNT-1 count selectable events.
module perf_counter_bank
  import perf_cnt_pkg::*;
#(
  parameter int          NUM_CNT  = 16,
  parameter int          CNT_W    = 32,
  parameter int          EVT_W    = 16,
  parameter logic [31:0] ROLL_MAX = 32'd999_999_999
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EVT_W-1:0]         evt,
  input  logic                     freeze,
  input  logic                     clear,
  perf_counter_bank_if.slave       bus,
  output logic [NUM_CNT*CNT_W-1:0] cnt_flat,
  output logic [CNT_W-1:0]         cnt_hi,
  output logic [NUM_CNT-1:0]       ovf
);

  localparam logic [CNT_W-1:0]  ROLL     = CNT_W'(ROLL_MAX);
  localparam logic [ADDR_W-1:0] HI_ADDR  = ADDR_W'(hi_ofs(NUM_CNT));
  localparam logic [ADDR_W-1:0] OVF_ADDR = ADDR_W'(ovf_ofs(NUM_CNT));

  logic [CNT_W-1:0] c0_q, c0_d, hi_q, hi_d;
  logic [CNT_W-1:0] rd_data_q, rd_mux, ovf_rd;
  logic             rd_valid_q;
  cnt_cfg_t         cfg_wr;

  always_comb begin
    c0_d = c0_q;
    hi_d = hi_q;
    if (clear) begin
      c0_d = '0;
      hi_d = '0;
    end else if (!freeze) begin
      if (c0_q == ROLL) begin
        c0_d = '0;
        hi_d = hi_q + 1'b1;
      end else begin
        c0_d = c0_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c0_q <= '0;
      hi_q <= '0;
    end else begin
      c0_q <= c0_d;
      hi_q <= hi_d;
    end
  end

  assign cfg_wr                  = decode_cfg(bus.cfg_wdata);
  assign cnt_flat[CNT_W-1:0]     = c0_q;
  assign ovf[0]                  = 1'b0;
  assign cnt_hi                  = hi_q;

  for (genvar gi = 1; gi < NUM_CNT; gi++) begin : g_slice
    perf_cnt_slice #(
      .CNT_W (CNT_W),
      .EVT_W (EVT_W),
      .IDX   (gi)
    ) u_slice (
      .clk        (clk),
      .rst_n      (rst),
      .evt_i      (evt),
      .freeze_i   (freeze),
      .clear_i    (clear),
      .cfg_wen_i  (bus.cfg_wen),
      .cfg_addr_i (bus.cfg_addr),
      .cfg_wr_i   (cfg_wr),
      .cnt_o      (cnt_flat[gi*CNT_W +: CNT_W]),
      .ovf_o      (ovf[gi])
    );
  end

  // The ovf vector is truncated or zero-extended to the read data width.
  for (genvar gi = 0; gi < CNT_W; gi++) begin : g_ovf_rd
    if (gi < NUM_CNT) begin : g_bit
      assign ovf_rd[gi] = ovf[gi];
    end else begin : g_pad
      assign ovf_rd[gi] = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (bus.rd_addr == ADDR_W'(i)) rd_mux = cnt_flat[i*CNT_W +: CNT_W];
    end
    if (bus.rd_addr == HI_ADDR)  rd_mux = hi_q;
    if (bus.rd_addr == OVF_ADDR) rd_mux = ovf_rd;
  end

  // Single-entry response buffer; a new request is only seen once it drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (rd_valid_q) begin
      if (bus.rd_data_ready) rd_valid_q <= 1'b0;
    end else if (bus.rd_req_valid) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= rd_mux;
    end
  end

  assign bus.rd_req_ready  = ~rd_valid_q;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.rd_data       = rd_data_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed scenarios for perf_counter_bank with NUM_CNT=16, CNT_W=8, ROLL_MAX=9.
module tb_perf_counter_bank;
  import perf_cnt_pkg::*;

  localparam int NUM_CNT = 16;
  localparam int CNT_W   = 8;
  localparam int EVT_W   = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     freeze = 1'b0;
  logic                     clear = 1'b0;
  logic [EVT_W-1:0]         evt = '0;
  logic [NUM_CNT*CNT_W-1:0] cnt_flat;
  logic [CNT_W-1:0]         cnt_hi;
  logic [NUM_CNT-1:0]       ovf;

  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] c0_m = '0;
  logic [CNT_W-1:0] hi_m = '0;

  perf_counter_bank_if #(.CNT_W(CNT_W)) bus ();

  perf_counter_bank #(
    .NUM_CNT  (NUM_CNT),
    .CNT_W    (CNT_W),
    .EVT_W    (EVT_W),
    .ROLL_MAX (32'd9)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .evt      (evt),
    .freeze   (freeze),
    .clear    (clear),
    .bus      (bus),
    .cnt_flat (cnt_flat),
    .cnt_hi   (cnt_hi),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cnt(input int i);
    return cnt_flat[i*CNT_W +: CNT_W];
  endfunction

  // Advance one clock; the counter-0 model follows the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst || clear) begin
      c0_m = '0;
      hi_m = '0;
    end else if (!freeze) begin
      if (c0_m == 8'd9) begin
        c0_m = '0;
        hi_m = hi_m + 8'd1;
      end else begin
        c0_m = c0_m + 8'd1;
      end
    end
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [9:0] d);
    bus.cfg_wen   = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick();
    bus.cfg_wen   = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a);
    bus.rd_addr       = a;
    bus.rd_req_valid  = 1'b1;
    bus.rd_data_ready = 1'b0;
    tick();
    bus.rd_req_valid  = 1'b0;
    for (int k = 0; k < 4 && !bus.rd_data_valid; k++) tick();
    checks++;
    if (bus.rd_data_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_timeout addr=%0d rd_data_valid=%b expected 1", a, bus.rd_data_valid);
    end
  endtask

  task automatic drain();
    bus.rd_data_ready = 1'b1;
    tick();
    bus.rd_data_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++; if (cnt_flat !== '0) begin errors++; $display("FAIL reset_cnt got=%0h exp=0", cnt_flat); end
    checks++; if (cnt_hi !== 8'd0) begin errors++; $display("FAIL reset_hi got=%0d exp=0", cnt_hi); end
    checks++; if (ovf !== 16'h0) begin errors++; $display("FAIL reset_ovf got=%0h exp=0", ovf); end
    checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", bus.rd_data_valid); end
    checks++; if (bus.rd_data !== 8'd0) begin errors++; $display("FAIL reset_rdata got=%0h exp=0", bus.rd_data); end
    checks++; if (bus.rd_req_ready !== 1'b1) begin errors++; $display("FAIL reset_rready got=%b exp=1", bus.rd_req_ready); end
    rst = 1'b1;
    repeat (25) tick();
    checks++; if (cnt(0) !== 8'd5) begin errors++; $display("FAIL roll_c0 got=%0d exp=5", cnt(0)); end
    checks++; if (cnt_hi !== 8'd2) begin errors++; $display("FAIL roll_hi got=%0d exp=2", cnt_hi); end
    $display("test_reset: c0=%0d hi=%0d", cnt(0), cnt_hi);
  endtask

  task automatic test_saturate();
    cfg_write(4'd1, 10'h303);
    evt = 16'h0008;
    repeat (300) tick();
    evt = '0;
    checks++; if (cnt(1) !== 8'd255) begin errors++; $display("FAIL sat_cnt1 got=%0d exp=255", cnt(1)); end
    checks++; if (ovf !== 16'h0002) begin errors++; $display("FAIL sat_ovf got=%0h exp=0002", ovf); end
    cfg_write(4'd1, 10'h203);
    checks++; if (cnt(1) !== 8'd255) begin errors++; $display("FAIL cfg_keeps_cnt got=%0d exp=255", cnt(1)); end
    evt = 16'h0008;
    tick();
    evt = '0;
    checks++; if (cnt(1) !== 8'd0) begin errors++; $display("FAIL wrap_cnt1 got=%0d exp=0", cnt(1)); end
    checks++; if (ovf !== 16'h0002) begin errors++; $display("FAIL wrap_ovf got=%0h exp=0002", ovf); end
    checks++; if (cnt(0) !== c0_m) begin errors++; $display("FAIL sat_c0 got=%0d exp=%0d", cnt(0), c0_m); end
    $display("test_saturate: cnt1=%0d ovf=%0h", cnt(1), ovf);
  endtask

  task automatic test_clear_same_cycle();
    evt = 16'h0008;
    tick(); tick();
    evt = '0;
    checks++; if (cnt(1) !== 8'd2) begin errors++; $display("FAIL pre_clear_cnt1 got=%0d exp=2", cnt(1)); end
    clear = 1'b1;
    evt   = 16'h0008;
    tick();
    clear = 1'b0;
    evt   = '0;
    checks++; if (cnt(1) !== 8'd0) begin errors++; $display("FAIL clear_cnt1 got=%0d exp=0", cnt(1)); end
    checks++; if (ovf !== 16'h0) begin errors++; $display("FAIL clear_ovf got=%0h exp=0", ovf); end
    checks++; if (cnt(0) !== 8'd0) begin errors++; $display("FAIL clear_c0 got=%0d exp=0", cnt(0)); end
    checks++; if (cnt_hi !== 8'd0) begin errors++; $display("FAIL clear_hi got=%0d exp=0", cnt_hi); end
    evt = 16'h0008;
    tick();
    evt = '0;
    checks++; if (cnt(1) !== 8'd1) begin errors++; $display("FAIL cfg_retained got=%0d exp=1", cnt(1)); end
    checks++; if (cnt(0) !== 8'd1) begin errors++; $display("FAIL post_clear_c0 got=%0d exp=1", cnt(0)); end
    $display("test_clear_same_cycle: cnt1=%0d", cnt(1));
  endtask

  task automatic test_bad_select();
    cfg_write(4'd3, 10'h214);
    cfg_write(4'd0, 10'h208);
    evt = 16'hFFFF;
    repeat (4) tick();
    evt = '0;
    checks++; if (cnt(3) !== 8'd0) begin errors++; $display("FAIL sel_out_of_range got=%0d exp=0", cnt(3)); end
    checks++; if (cnt(1) !== 8'd5) begin errors++; $display("FAIL sel3_cnt1 got=%0d exp=5", cnt(1)); end
    checks++; if (cnt(4) !== 8'd0) begin errors++; $display("FAIL disabled_cnt4 got=%0d exp=0", cnt(4)); end
    checks++; if (cnt(0) !== c0_m) begin errors++; $display("FAIL cfg0_ignored_c0 got=%0d exp=%0d", cnt(0), c0_m); end
    $display("test_bad_select: cnt3=%0d cnt1=%0d", cnt(3), cnt(1));
  endtask

  task automatic test_freeze();
    cfg_write(4'd2, 10'h205);
    for (int p = 0; p < 7; p++) begin
      freeze = (p == 1 || p == 3 || p == 5);
      evt    = 16'h0020;
      tick();
      evt    = '0;
      freeze = 1'b0;
      tick();
    end
    checks++; if (cnt(2) !== 8'd4) begin errors++; $display("FAIL freeze_cnt2 got=%0d exp=4", cnt(2)); end
    checks++; if (cnt(1) !== 8'd5) begin errors++; $display("FAIL freeze_cnt1 got=%0d exp=5", cnt(1)); end
    checks++; if (cnt(0) !== c0_m) begin errors++; $display("FAIL freeze_c0 got=%0d exp=%0d", cnt(0), c0_m); end
    checks++; if (cnt_hi !== hi_m) begin errors++; $display("FAIL freeze_hi got=%0d exp=%0d", cnt_hi, hi_m); end
    $display("test_freeze: cnt2=%0d c0=%0d", cnt(2), cnt(0));
  endtask

  task automatic test_read();
    cfg_write(4'd5, 10'h307);
    evt = 16'h0080;
    repeat (260) tick();
    evt = '0;
    checks++; if (ovf !== 16'h0020) begin errors++; $display("FAIL ovf5 got=%0h exp=0020", ovf); end
    freeze = 1'b1;
    do_read(5'd1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.rd_data !== 8'd5) begin errors++; $display("FAIL hold_rdata cyc=%0d got=%0d exp=5", k, bus.rd_data); end
      checks++; if (bus.rd_data_valid !== 1'b1) begin errors++; $display("FAIL hold_rvalid cyc=%0d got=%b exp=1", k, bus.rd_data_valid); end
      checks++; if (bus.rd_req_ready !== 1'b0) begin errors++; $display("FAIL hold_rready cyc=%0d got=%b exp=0", k, bus.rd_req_ready); end
      tick();
    end
    bus.rd_data_ready = 1'b1;
    bus.rd_req_valid  = 1'b1;
    bus.rd_addr       = 5'd16;
    tick();
    checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap_rvalid got=%b exp=0", bus.rd_data_valid); end
    tick();
    bus.rd_req_valid  = 1'b0;
    checks++; if (bus.rd_data_valid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid got=%b exp=1", bus.rd_data_valid); end
    checks++; if (bus.rd_data !== hi_m) begin errors++; $display("FAIL read_hi got=%0d exp=%0d", bus.rd_data, hi_m); end
    tick();
    bus.rd_data_ready = 1'b0;
    checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL drain_rvalid got=%b exp=0", bus.rd_data_valid); end
    do_read(5'd17);
    checks++; if (bus.rd_data !== 8'h20) begin errors++; $display("FAIL read_ovf got=%0h exp=20", bus.rd_data); end
    drain();
    do_read(5'd20);
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL read_unmapped got=%0h exp=0", bus.rd_data); end
    drain();
    freeze = 1'b0;
    bus.rd_addr      = 5'd1;
    bus.rd_req_valid = 1'b1;
    clear            = 1'b1;
    tick();
    clear            = 1'b0;
    bus.rd_req_valid = 1'b0;
    checks++; if (bus.rd_data !== 8'd5) begin errors++; $display("FAIL read_in_clear got=%0d exp=5", bus.rd_data); end
    checks++; if (cnt(1) !== 8'd0) begin errors++; $display("FAIL read_clear_cnt1 got=%0d exp=0", cnt(1)); end
    drain();
    $display("test_read: hi=%0d ovf=%0h", hi_m, ovf);
  endtask

  task automatic test_hi_wrap();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (2559) tick();
    checks++; if (cnt(0) !== 8'd9) begin errors++; $display("FAIL prewrap_c0 got=%0d exp=9", cnt(0)); end
    checks++; if (cnt_hi !== 8'd255) begin errors++; $display("FAIL prewrap_hi got=%0d exp=255", cnt_hi); end
    tick();
    checks++; if (cnt(0) !== 8'd0) begin errors++; $display("FAIL wrap_c0 got=%0d exp=0", cnt(0)); end
    checks++; if (cnt_hi !== 8'd0) begin errors++; $display("FAIL wrap_hi got=%0d exp=0", cnt_hi); end
    $display("test_hi_wrap: c0=%0d hi=%0d", cnt(0), cnt_hi);
  endtask

  task automatic test_reset_async();
    evt = 16'h0080;
    repeat (3) tick();
    evt = '0;
    do_read(5'd5);
    checks++; if (bus.rd_data !== 8'd3) begin errors++; $display("FAIL pre_rst_read got=%0d exp=3", bus.rd_data); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL async_rvalid got=%b exp=0", bus.rd_data_valid); end
    checks++; if (bus.rd_data !== 8'd0) begin errors++; $display("FAIL async_rdata got=%0h exp=0", bus.rd_data); end
    checks++; if (cnt_flat !== '0) begin errors++; $display("FAIL async_cnt got=%0h exp=0", cnt_flat); end
    c0_m = '0;
    hi_m = '0;
    tick();
    rst = 1'b1;
    evt = 16'h0088;
    repeat (3) tick();
    evt = '0;
    checks++; if (cnt(0) !== 8'd3) begin errors++; $display("FAIL resume_c0 got=%0d exp=3", cnt(0)); end
    checks++; if (cnt(1) !== 8'd0) begin errors++; $display("FAIL cfg_reset_cnt1 got=%0d exp=0", cnt(1)); end
    checks++; if (cnt(5) !== 8'd0) begin errors++; $display("FAIL cfg_reset_cnt5 got=%0d exp=0", cnt(5)); end
    $display("test_reset_async: c0=%0d", cnt(0));
  endtask

  initial begin
    bus.cfg_wen       = 1'b0;
    bus.cfg_addr      = '0;
    bus.cfg_wdata     = '0;
    bus.rd_req_valid  = 1'b0;
    bus.rd_addr       = '0;
    bus.rd_data_ready = 1'b0;
    test_reset();
    test_saturate();
    test_clear_same_cycle();
    test_bad_select();
    test_freeze();
    test_read();
    test_hi_wrap();
    test_reset_async();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after 2000000 time units");
    $fatal(1, "watchdog");
  end

endmodule
